// File: rtl/up5bit_counter_dual_clock.sv
// Two independent 5-bit up-counters on one clock: channel 0 counts every clk0
// cycle, channel 1 counts synchronised rising edges of the asynchronous tick1.
module up5bit_counter_dual_clock (
  input  logic       clk0,
  input  logic       reset,
  input  logic       tick1,
  output logic [4:0] out0,
  output logic [4:0] out1,
  output logic       wrap0,
  output logic       wrap1
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_rise;

  // r_s3 holds the previous synchronised level, so a held-high tick1 yields one pulse.
  assign w_rise = r_s2 & ~r_s3;

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      out0  <= '0;
      out1  <= '0;
      wrap0 <= 1'b0;
      wrap1 <= 1'b0;
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
    end else begin
      r_s1  <= tick1;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      out0  <= out0 + 5'd1;
      wrap0 <= (out0 == 5'd31);
      if (w_rise) begin
        out1 <= out1 + 5'd1;
      end
      wrap1 <= w_rise && (out1 == 5'd31);
    end
  end

endmodule

// File: tb/tb_up5bit_counter_dual_clock.sv
// Randomised and directed checks of up5bit_counter_dual_clock against an
// edge-history reference model (counts of clk0 edges and sampled tick1 rises).
module tb_up5bit_counter_dual_clock;

  logic       clk0;
  logic       reset;
  logic       tick1;
  logic [4:0] out0;
  logic [4:0] out1;
  logic       wrap0;
  logic       wrap1;

  int unsigned n_cmp;
  int unsigned n_bad;

  // Reference model state: tick1 level seen at each edge since release.
  bit          hist[$];
  int unsigned n_edges;
  int unsigned n_rises;
  bit          exp_wrap1;

  up5bit_counter_dual_clock dut (
    .clk0  (clk0),
    .reset (reset),
    .tick1 (tick1),
    .out0  (out0),
    .out1  (out1),
    .wrap0 (wrap0),
    .wrap1 (wrap1)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out0"},  int'(out0),  0);
    chk({tag, "_out1"},  int'(out1),  0);
    chk({tag, "_wrap0"}, int'(wrap0), 0);
    chk({tag, "_wrap1"}, int'(wrap1), 0);
  endtask

  task automatic model_clear();
    hist.delete();
    n_edges   = 0;
    n_rises   = 0;
    exp_wrap1 = 1'b0;
  endtask

  // One clk0 edge: advance model, then compare all outputs 1ns later.
  task automatic step();
    int unsigned j;
    bit prev;
    @(posedge clk0);
    hist.push_back(tick1);
    n_edges++;
    exp_wrap1 = 1'b0;
    if (n_edges >= 3) begin
      j = n_edges - 3;
      prev = (j == 0) ? 1'b0 : hist[j-1];
      if (hist[j] && !prev) begin
        n_rises++;
        exp_wrap1 = (n_rises % 32 == 0);
      end
    end
    #1;
    chk("out0",  int'(out0),  int'(n_edges % 32));
    chk("wrap0", int'(wrap0), int'(n_edges % 32 == 0));
    chk("out1",  int'(out1),  int'(n_rises % 32));
    chk("wrap1", int'(wrap1), int'(exp_wrap1));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    tick1 = 1'b1;
    run(hi);
    tick1 = 1'b0;
    run(lo);
  endtask

  // Called just after an active edge: assert reset mid-cycle, hold 2 edges, release near negedge.
  task automatic do_reset(input bit tick_at_release);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_async");
    model_clear();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk0);
      #1;
      chk_all_zero("rst_hold");
    end
    tick1 = tick_at_release;
    #3;
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_clear();
    tick1 = 1'b0;
    reset = 1'b0;
    #1;
    chk_all_zero("por");
    repeat (2) @(posedge clk0);
    #1;
    chk_all_zero("por_hold");
    #3;
    reset = 1'b1;

    // Free-running channel 0 with tick1 idle, across a rollover.
    run(34);

    // 32 regular pulses wrap channel 1.
    for (int i = 0; i < 32; i++) pulse(3, 3);

    // Held level counts once.
    pulse(20, 4);

    // Random legal pulse widths.
    for (int i = 0; i < 60; i++) pulse($urandom_range(2, 7), $urandom_range(2, 7));

    // Reset mid-count at out0=17, out1=5.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) pulse(2, 2);
    for (int i = 0; i < 40 && (n_edges % 32) != 17; i++) step();
    chk("pre_rst_out0", int'(out0), 17);
    chk("pre_rst_out1", int'(out1), 5);
    do_reset(1'b0);
    run(3);

    // Release with tick1 already high.
    do_reset(1'b1);
    run(3);
    chk("rel_high_out1", int'(out1), 1);
    run(10);
    tick1 = 1'b0;
    run(5);

    // More random stimulus, including short idle spans.
    for (int i = 0; i < 80; i++) pulse($urandom_range(2, 5), $urandom_range(2, 9));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
